// File: rtl/memory_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : memory_stage_lsu
// Brief    : RV32 MEM stage with sized loads/stores, fault flag, load wait FSM
//            and the MEM/WB pipeline register.
// Revision : 1.0
// ============================================================================
module memory_stage_lsu #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 0,
    parameter int REGW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            RegWriteM,
    input  logic            MemWriteM,
    input  logic            MemReadM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic [REGW-1:0] RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic            FlushM,
    output logic            MemBusyM,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [XLEN-1:0] ALUResultW,
    output logic [XLEN-1:0] ReadDataW,
    output logic [REGW-1:0] RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic            FaultW
);

    localparam int         c_AW  = $clog2(DEPTH);
    localparam int         c_NB  = XLEN / 8;
    localparam logic [3:0] c_LAT = 4'(RD_LAT);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    logic [XLEN-1:0] r_mem [DEPTH];
    state_t          r_state, w_state_nxt;
    logic [3:0]      r_cnt, w_cnt_nxt;

    logic [c_AW-1:0] w_idx;
    logic [1:0]      w_lane;
    logic            w_ld_f3_ok, w_st_f3_ok, w_fault;
    logic            w_load_ok, w_store_ok, w_bubble;
    logic [c_NB-1:0] w_be;
    logic [XLEN-1:0] w_wdata, w_rword, w_ext;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;

    assign w_idx  = ALUResultM[c_AW+1:2];
    assign w_lane = ALUResultM[1:0];

    assign w_ld_f3_ok = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010) ||
                        (Funct3M == 3'b100) || (Funct3M == 3'b101);
    assign w_st_f3_ok = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010);

    assign w_fault = (MemReadM | MemWriteM) &
                     ((MemReadM & MemWriteM) |
                      (MemReadM & ~w_ld_f3_ok) |
                      (MemWriteM & ~w_st_f3_ok) |
                      ((Funct3M[1:0] == 2'b01) & w_lane[0]) |
                      ((Funct3M[1:0] == 2'b10) & (w_lane != 2'b00)));

    assign w_load_ok  = MemReadM  & ~MemWriteM & ~w_fault & ~FlushM;
    assign w_store_ok = MemWriteM & ~MemReadM  & ~w_fault & ~FlushM;

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        w_be    = '0;
        w_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                w_be[w_lane] = 1'b1;
                w_wdata      = {c_NB{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_be[{w_lane[1], 1'b0}] = 1'b1;
                w_be[{w_lane[1], 1'b1}] = 1'b1;
                w_wdata                 = {(c_NB/2){WriteDataM[15:0]}};
            end
            default: w_be = '1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_store_ok) begin
            for (int b = 0; b < c_NB; b++) begin
                if (w_be[b]) r_mem[w_idx][b*8 +: 8] <= w_wdata[b*8 +: 8];
            end
        end
    end

    assign w_rword = r_mem[w_idx];
    assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
    assign w_half  = w_rword[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        w_ext = '0;
        case (Funct3M)
            3'b000:  w_ext = {{(XLEN-8){w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{(XLEN-16){w_half[15]}}, w_half};
            3'b010:  w_ext = w_rword;
            3'b100:  w_ext = {{(XLEN-8){1'b0}}, w_byte};
            3'b101:  w_ext = {{(XLEN-16){1'b0}}, w_half};
            default: w_ext = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The load finishes in the WAIT cycle where cnt reaches RD_LAT; earlier cycles bubble W.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        MemBusyM    = 1'b0;
        w_bubble    = 1'b0;
        if (FlushM) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 4'd0;
            w_bubble    = 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_load_ok && (c_LAT != 4'd0)) begin
                        MemBusyM    = 1'b1;
                        w_bubble    = 1'b1;
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                S_WAIT: begin
                    if (r_cnt < c_LAT) begin
                        MemBusyM  = 1'b1;
                        w_bubble  = 1'b1;
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_cnt_nxt   = 4'd0;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'b00;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            RD_W       <= '0;
            PCPlus4W   <= '0;
            FaultW     <= 1'b0;
        end else begin
            RegWriteW  <= RegWriteM & ~w_bubble & ~w_fault;
            ResultSrcW <= ResultSrcM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= (w_load_ok && !w_bubble) ? w_ext : '0;
            RD_W       <= RD_M;
            PCPlus4W   <= PCPlus4M;
            FaultW     <= w_fault & ~FlushM;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_stage_lsu
// Brief    : Directed vector bench for memory_stage_lsu (RD_LAT 0 and 3 instances).
// Revision : 1.0
// ============================================================================
module tb_memory_stage_lsu;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteM, MemWriteM, MemReadM, FlushM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
    logic [4:0]  RD_M;

    logic        busy0, rw0, flt0, busy3, rw3, flt3;
    logic [1:0]  rs0, rs3;
    logic [31:0] alu0, rd0, pc0, alu3, rd3, pc3;
    logic [4:0]  rdw0, rdw3;

    int nvec  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    memory_stage_lsu #(.XLEN(32), .DEPTH(1024), .RD_LAT(0), .REGW(5)) u_d0 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .FlushM(FlushM), .MemBusyM(busy0), .RegWriteW(rw0),
        .ResultSrcW(rs0), .ALUResultW(alu0), .ReadDataW(rd0), .RD_W(rdw0), .PCPlus4W(pc0), .FaultW(flt0)
    );

    memory_stage_lsu #(.XLEN(32), .DEPTH(1024), .RD_LAT(3), .REGW(5)) u_d3 (
        .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
        .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .FlushM(FlushM), .MemBusyM(busy3), .RegWriteW(rw3),
        .ResultSrcW(rs3), .ALUResultW(alu3), .ReadDataW(rd3), .RD_W(rdw3), .PCPlus4W(pc3), .FaultW(flt3)
    );

    typedef struct {
        logic        rw, we, re;
        logic [2:0]  f3;
        logic [31:0] addr, wd;
        logic        fl;
        logic        erw, eflt;
        logic [31:0] erd;
    } vec_t;

    function automatic vec_t mk(input logic rw, input logic we, input logic re, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] wd, input logic fl,
                                input logic erw, input logic eflt, input logic [31:0] erd);
        vec_t v;
        v.rw = rw; v.we = we; v.re = re; v.f3 = f3; v.addr = addr; v.wd = wd; v.fl = fl;
        v.erw = erw; v.eflt = eflt; v.erd = erd;
        return v;
    endfunction

    task automatic setm(input logic rw, input logic we, input logic re, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input logic fl);
        RegWriteM  = rw;
        MemWriteM  = we;
        MemReadM   = re;
        Funct3M    = f3;
        ALUResultM = addr;
        WriteDataM = wd;
        FlushM     = fl;
        ResultSrcM = re ? 2'b01 : 2'b00;
        PCPlus4M   = addr + 32'd4;
        RD_M       = addr[6:2] ^ 5'd7;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Full RD_LAT=3 load on u_d3: three busy/bubble cycles, then data in W.
    task automatic load3(input logic [31:0] addr, input logic [31:0] exp);
        setm(1'b1, 1'b0, 1'b1, 3'b010, addr, 32'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("d3 busy c%0d", k), {31'd0, busy3}, 32'd1);
            @(posedge clk); #1;
            chk($sformatf("d3 bubble c%0d", k), {30'd0, rw3, flt3}, 32'd0);
        end
        #1 chk("d3 busy done", {31'd0, busy3}, 32'd0);
        @(posedge clk); #1;
        chk("d3 load rw", {31'd0, rw3}, 32'd1);
        chk("d3 load data", rd3, exp);
    endtask

    vec_t tbl[25];

    initial begin
        tbl[0]  = mk(0, 1, 0, 3'b010, 32'h10,   32'hDEADBEEF, 0, 0, 0, 32'h0);
        tbl[1]  = mk(1, 0, 1, 3'b010, 32'h10,   32'h0,        0, 1, 0, 32'hDEADBEEF);
        tbl[2]  = mk(0, 1, 0, 3'b000, 32'h13,   32'h80,       0, 0, 0, 32'h0);
        tbl[3]  = mk(1, 0, 1, 3'b000, 32'h13,   32'h0,        0, 1, 0, 32'hFFFFFF80);
        tbl[4]  = mk(1, 0, 1, 3'b100, 32'h13,   32'h0,        0, 1, 0, 32'h00000080);
        tbl[5]  = mk(1, 0, 1, 3'b010, 32'h10,   32'h0,        0, 1, 0, 32'h80ADBEEF);
        tbl[6]  = mk(1, 0, 1, 3'b001, 32'h11,   32'h0,        0, 0, 1, 32'h0);
        tbl[7]  = mk(0, 1, 0, 3'b010, 32'h12,   32'h12345678, 0, 0, 1, 32'h0);
        tbl[8]  = mk(1, 0, 1, 3'b010, 32'h10,   32'h0,        0, 1, 0, 32'h80ADBEEF);
        tbl[9]  = mk(0, 1, 0, 3'b010, 32'h14,   32'h11223344, 0, 0, 0, 32'h0);
        tbl[10] = mk(0, 1, 0, 3'b001, 32'h16,   32'h0000CAFE, 0, 0, 0, 32'h0);
        tbl[11] = mk(1, 0, 1, 3'b010, 32'h14,   32'h0,        0, 1, 0, 32'hCAFE3344);
        tbl[12] = mk(1, 0, 1, 3'b001, 32'h16,   32'h0,        0, 1, 0, 32'hFFFFCAFE);
        tbl[13] = mk(1, 0, 1, 3'b101, 32'h16,   32'h0,        0, 1, 0, 32'h0000CAFE);
        tbl[14] = mk(1, 0, 1, 3'b000, 32'h15,   32'h0,        0, 1, 0, 32'h00000033);
        tbl[15] = mk(1, 0, 1, 3'b011, 32'h10,   32'h0,        0, 0, 1, 32'h0);
        tbl[16] = mk(1, 1, 1, 3'b010, 32'h10,   32'h0,        0, 0, 1, 32'h0);
        tbl[17] = mk(0, 1, 0, 3'b010, 32'h10,   32'h55,       1, 0, 0, 32'h0);
        tbl[18] = mk(1, 0, 1, 3'b010, 32'h10,   32'h0,        0, 1, 0, 32'h80ADBEEF);
        tbl[19] = mk(1, 0, 1, 3'b010, 32'h1010, 32'h0,        0, 1, 0, 32'h80ADBEEF);
        tbl[20] = mk(1, 0, 0, 3'b000, 32'h77,   32'h0,        0, 1, 0, 32'h0);
        tbl[21] = mk(1, 0, 0, 3'b000, 32'h78,   32'h0,        1, 0, 0, 32'h0);
        tbl[22] = mk(1, 0, 1, 3'b000, 32'h10,   32'h0,        0, 1, 0, 32'hFFFFFFEF);
        tbl[23] = mk(1, 0, 1, 3'b001, 32'h12,   32'h0,        0, 1, 0, 32'hFFFF80AD);
        tbl[24] = mk(1, 0, 1, 3'b100, 32'h11,   32'h0,        0, 1, 0, 32'h000000BE);

        rst = 1'b0;
        setm(0, 0, 0, 3'b000, 32'h0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset d0", {rw0, flt0, rs0, rdw0} | alu0 | rd0 | pc0, 32'd0);
        chk("reset d3", {rw3, flt3, rs3, rdw3} | alu3 | rd3 | pc3, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < 25; i++) begin
            logic ok;
            setm(tbl[i].rw, tbl[i].we, tbl[i].re, tbl[i].f3, tbl[i].addr, tbl[i].wd, tbl[i].fl);
            #1;
            ok = (busy0 === 1'b0);
            @(posedge clk); #1;
            ok = ok && (rw0 === tbl[i].erw) && (flt0 === tbl[i].eflt) &&
                 (alu0 === tbl[i].addr) && (pc0 === tbl[i].addr + 32'd4) &&
                 (rdw0 === (tbl[i].addr[6:2] ^ 5'd7));
            if (tbl[i].re || tbl[i].eflt) ok = ok && (rd0 === tbl[i].erd);
            nvec++;
            if (!ok) begin
                nfail++;
                $display("FAIL vec%0d: got rw=%b flt=%b rd=%h alu=%h busy=%b expected rw=%b flt=%b rd=%h alu=%h",
                         i, rw0, flt0, rd0, alu0, busy0, tbl[i].erw, tbl[i].eflt, tbl[i].erd, tbl[i].addr);
            end
        end

        // Clean FSM state in u_d3 after the shared table traffic.
        @(negedge clk);
        rst = 1'b0;
        setm(0, 0, 0, 3'b000, 32'h0, 32'h0, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Waited load, then a store that must not wait, then read it back.
        load3(32'h10, 32'h80ADBEEF);
        setm(0, 1, 0, 3'b010, 32'h20, 32'hA5A5A5A5, 0);
        #1 chk("d3 store busy", {31'd0, busy3}, 32'd0);
        @(posedge clk); #1;
        chk("d3 store w", {30'd0, rw3, flt3}, 32'd0);
        load3(32'h20, 32'hA5A5A5A5);

        // Flush in the second wait cycle.
        setm(1, 0, 1, 3'b010, 32'h10, 32'h0, 0);
        #1 chk("flush pre busy", {31'd0, busy3}, 32'd1);
        @(posedge clk); #1;
        setm(1, 0, 1, 3'b010, 32'h10, 32'h0, 1);
        #1 chk("flush busy", {31'd0, busy3}, 32'd0);
        @(posedge clk); #1;
        chk("flush rw", {31'd0, rw3}, 32'd0);
        load3(32'h10, 32'h80ADBEEF);

        // Flushed store leaves memory alone.
        setm(0, 1, 0, 3'b010, 32'h20, 32'h99, 1);
        @(posedge clk); #1;
        load3(32'h20, 32'hA5A5A5A5);

        // Reset in the middle of a wait aborts the load.
        setm(1, 0, 1, 3'b010, 32'h14, 32'h0, 0);
        @(posedge clk); #1;
        chk("pre-reset alu", alu3, 32'h14);
        #2 rst = 1'b0;
        #1;
        chk("async reset d3", {rw3, flt3, rs3, rdw3} | alu3 | rd3 | pc3, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        load3(32'h14, 32'hCAFE3344);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
`default_nettype wire
